// File: rtl/vga_timing_if.sv
// Bundles the pixel-enable, scroll and line-compare inputs with all raster timing outputs.
// master: the timing generator side; slave: the fetch/display/CPU consumer side.
interface vga_timing_if #(
   parameter int unsigned HW = 10,
   parameter int unsigned VW = 9,
   parameter int unsigned SW = 7
);
   logic          pix_en;
   logic [SW-1:0] scroll_x;
   logic [SW-1:0] scroll_y;
   logic [VW-1:0] raster_line;
   logic [HW-1:0] counter_x;
   logic [VW-1:0] counter_y;
   logic [HW-1:0] scr_x;
   logic [VW-1:0] scr_y;
   logic          in_display;
   logic          hsync;
   logic          vsync;
   logic          pix_phase;
   logic          frame_irq;
   logic          line_irq;
   logic          raster_irq;

   modport master (
      input  pix_en, scroll_x, scroll_y, raster_line,
      output counter_x, counter_y, scr_x, scr_y, in_display, hsync, vsync,
      output pix_phase, frame_irq, line_irq, raster_irq
   );

   modport slave (
      output pix_en, scroll_x, scroll_y, raster_line,
      input  counter_x, counter_y, scr_x, scr_y, in_display, hsync, vsync,
      input  pix_phase, frame_irq, line_irq, raster_irq
   );
endinterface

// File: rtl/vga_timing_core.sv
// Parametrised raster timing generator: pixel/line counters, registered sync/window/scroll
// outputs and frame/line interrupt pulses. Define RASTER_IRQ_EN to enable the line-compare irq.
module vga_timing_core #(
   parameter int unsigned HW           = 10,
   parameter int unsigned VW           = 9,
   parameter int unsigned SW           = 7,
   parameter int unsigned H_TOTAL      = 768,
   parameter int unsigned H_DISP_START = 101,
   parameter int unsigned H_DISP_END   = 700,
   parameter int unsigned H_SYNC_START = 720,
   parameter int unsigned H_SYNC_LEN   = 16,
   parameter int unsigned V_TOTAL      = 512,
   parameter int unsigned V_DISP_START = 21,
   parameter int unsigned V_DISP_END   = 500,
   parameter int unsigned V_SYNC_START = 500,
   parameter int unsigned V_SYNC_LEN   = 1,
   parameter int unsigned X_OFFSET     = 48,
   parameter bit          SYNC_NEG     = 1'b1
) (
   input logic         clk,
   input logic         rst,
   vga_timing_if.master bus
);

   logic [HW-1:0] cx_q, cx_d;
   logic [VW-1:0] cy_q, cy_d;
   logic [SW-1:0] shx_q, shy_q;
   logic [HW-1:0] scr_x_q, scr_x_d;
   logic [VW-1:0] scr_y_q, scr_y_d;
   logic          in_display_q, in_display_d;
   logic          hsync_q, vsync_q;
   logic          hs_act, vs_act;
   logic          pix_phase_q;
   logic          frame_irq_q, line_irq_q, raster_irq_q;
   logic          x_wrap, y_wrap, raster_hit;
   int unsigned   xi, yi;

   always_comb begin
      xi = 32'(cx_q);
      yi = 32'(cy_q);
      x_wrap = (xi == H_TOTAL - 1);
      y_wrap = (yi == V_TOTAL - 1);

      cx_d = x_wrap ? '0 : cx_q + 1'b1;
      cy_d = cy_q;
      if (x_wrap) begin
         cy_d = y_wrap ? '0 : cy_q + 1'b1;
      end

      // Stage-2 values come from the pre-update counters, one pixel tick behind.
      in_display_d = (xi >= H_DISP_START) && (xi < H_DISP_END) &&
                     (yi >= V_DISP_START) && (yi < V_DISP_END);
      hs_act  = (xi >= H_SYNC_START) && (xi < H_SYNC_START + H_SYNC_LEN);
      vs_act  = (yi >= V_SYNC_START) && (yi < V_SYNC_START + V_SYNC_LEN);
      scr_x_d = HW'(xi + 32'({shx_q, 1'b0}) - X_OFFSET);
      scr_y_d = VW'(yi + 32'({shy_q, 1'b0}));

`ifdef RASTER_IRQ_EN
      // cy_d never reaches V_TOTAL, so out-of-range compare values cannot fire.
      raster_hit = (32'(cy_d) == 32'(bus.raster_line));
`else
      raster_hit = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cx_q         <= '0;
         cy_q         <= '0;
         shx_q        <= '0;
         shy_q        <= '0;
         scr_x_q      <= '0;
         scr_y_q      <= '0;
         in_display_q <= 1'b0;
         hsync_q      <= SYNC_NEG;
         vsync_q      <= SYNC_NEG;
         pix_phase_q  <= 1'b0;
         frame_irq_q  <= 1'b0;
         line_irq_q   <= 1'b0;
         raster_irq_q <= 1'b0;
      end else begin
         pix_phase_q  <= cx_q[0];
         frame_irq_q  <= 1'b0;
         line_irq_q   <= 1'b0;
         raster_irq_q <= 1'b0;
         if (bus.pix_en) begin
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            scr_x_q      <= scr_x_d;
            scr_y_q      <= scr_y_d;
            in_display_q <= in_display_d;
            hsync_q      <= hs_act ^ SYNC_NEG;
            vsync_q      <= vs_act ^ SYNC_NEG;
            line_irq_q   <= x_wrap;
            raster_irq_q <= x_wrap && raster_hit;
            // Scroll is latched only at the frame wrap so a frame never tears.
            if (x_wrap && y_wrap) begin
               frame_irq_q <= 1'b1;
               shx_q       <= bus.scroll_x;
               shy_q       <= bus.scroll_y;
            end
         end
      end
   end

   assign bus.counter_x  = cx_q;
   assign bus.counter_y  = cy_q;
   assign bus.scr_x      = scr_x_q;
   assign bus.scr_y      = scr_y_q;
   assign bus.in_display = in_display_q;
   assign bus.hsync      = hsync_q;
   assign bus.vsync      = vsync_q;
   assign bus.pix_phase  = pix_phase_q;
   assign bus.frame_irq  = frame_irq_q;
   assign bus.line_irq   = line_irq_q;
   assign bus.raster_irq = raster_irq_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Scoreboard bench for vga_timing_core on a reduced 20x10 raster: the driver pushes expected
// outputs per clock, a monitor pops and compares them plus hand-computed checkpoints.
module tb_vga_timing_core;

   localparam int HT = 20, HDS = 3, HDE = 15, HSS = 16, HSL = 2;
   localparam int VT = 10, VDS = 1, VDE = 8, VSS = 8, VSL = 1;
   localparam int XO = 5, FR = HT * VT;
   localparam int XMASK = 63, YMASK = 31;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_timing_if #(.HW(6), .VW(5), .SW(3)) bus ();

   vga_timing_core #(
      .HW(6), .VW(5), .SW(3),
      .H_TOTAL(HT), .H_DISP_START(HDS), .H_DISP_END(HDE), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_TOTAL(VT), .V_DISP_START(VDS), .V_DISP_END(VDE), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
      .X_OFFSET(XO), .SYNC_NEG(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int ph; int k; bit tick;
      int cx; int cy; int sx; int sy; int ind; int hs; int vs; int pp; int fr; int ln; int ra;
   } exp_t;

   typedef struct { int ph; int k; int fld; int val; } chk_t;

   exp_t q[$];
   chk_t dir[$];
   bit   hit[64];
   int   total = 0;
   int   bad = 0;
   int   phase = 0;
   int   k = 0;
   int   mshx = 0, mshy = 0;
   exp_t prev;
   string nm[11] = '{"counter_x", "counter_y", "scr_x", "scr_y", "in_display", "hsync",
                     "vsync", "pix_phase", "frame_irq", "line_irq", "raster_irq"};

   function automatic int exp_fld(input exp_t e, input int i);
      case (i)
         0: return e.cx;   1: return e.cy;   2: return e.sx;  3: return e.sy;
         4: return e.ind;  5: return e.hs;   6: return e.vs;  7: return e.pp;
         8: return e.fr;   9: return e.ln;   default: return e.ra;
      endcase
   endfunction

   function automatic int got_fld(input int i);
      case (i)
         0: return int'(bus.counter_x);  1: return int'(bus.counter_y);
         2: return int'(bus.scr_x);      3: return int'(bus.scr_y);
         4: return int'(bus.in_display); 5: return int'(bus.hsync);
         6: return int'(bus.vsync);      7: return int'(bus.pix_phase);
         8: return int'(bus.frame_irq);  9: return int'(bus.line_irq);
         default: return int'(bus.raster_irq);
      endcase
   endfunction

   // Reference model: counters derived from the tick count since reset.
   task automatic step(input bit r, input bit pe);
      exp_t e;
      int x, y;
      e = prev;
      @(negedge clk);
      rst = r;
      bus.pix_en = pe;
      if (r) begin
         k = 0; mshx = 0; mshy = 0;
         e.sx = 0; e.sy = 0; e.ind = 0; e.hs = 1; e.vs = 1; e.pp = 0;
         e.fr = 0; e.ln = 0; e.ra = 0; e.tick = 0;
      end else begin
         e.pp = (k % HT) % 2;
         e.fr = 0; e.ln = 0; e.ra = 0; e.tick = pe;
         if (pe) begin
            x = k % HT;
            y = (k / HT) % VT;
            e.ind = (x >= HDS && x < HDE && y >= VDS && y < VDE) ? 1 : 0;
            e.hs = (x >= HSS && x < HSS + HSL) ? 0 : 1;
            e.vs = (y >= VSS && y < VSS + VSL) ? 0 : 1;
            e.sx = (x + 2 * mshx - XO) & XMASK;
            e.sy = (y + 2 * mshy) & YMASK;
            k++;
            if (k % HT == 0) e.ln = 1;
            if (k % FR == 0) begin
               e.fr = 1;
               mshx = int'(bus.scroll_x);
               mshy = int'(bus.scroll_y);
            end
`ifdef RASTER_IRQ_EN
            e.ra = (e.ln == 1 && ((k / HT) % VT) == int'(bus.raster_line)) ? 1 : 0;
`endif
         end
      end
      e.cx = k % HT;
      e.cy = (k / HT) % VT;
      e.k = k;
      e.ph = phase;
      q.push_back(e);
      prev = e;
   endtask

   task automatic add(input int ph, input int kk, input int f, input int v);
      chk_t c;
      c.ph = ph; c.k = kk; c.fld = f; c.val = v;
      dir.push_back(c);
   endtask

   // Monitor: compares every field of each popped record, then any matching checkpoint.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < 11; i++) begin
               total++;
               if (got_fld(i) != exp_fld(e, i)) begin
                  bad++;
                  $display("FAIL %s ph=%0d k=%0d got=%0d want=%0d", nm[i], e.ph, e.k,
                           got_fld(i), exp_fld(e, i));
               end
            end
            for (int j = 0; j < dir.size(); j++) begin
               if (dir[j].ph == e.ph && dir[j].k == e.k && (e.tick || e.k == 0)) begin
                  hit[j] = 1'b1;
                  total++;
                  if (got_fld(dir[j].fld) != dir[j].val) begin
                     bad++;
                     $display("FAIL point_%s ph=%0d k=%0d got=%0d want=%0d", nm[dir[j].fld],
                              e.ph, e.k, got_fld(dir[j].fld), dir[j].val);
                  end
               end
            end
         end
      end
   end

   initial begin
      int guard;
      bus.pix_en = 1'b0;
      bus.scroll_x = '0;
      bus.scroll_y = '0;
      bus.raster_line = 5'd4;
      prev = '{default: 0};

      // Hand-computed checkpoints: fields 0 cx,1 cy,2 scr_x,3 scr_y,4 in_display,5 hsync,
      // 6 vsync,7 pix_phase,8 frame_irq,9 line_irq,10 raster_irq.
      add(0, 0, 0, 0);   add(0, 0, 5, 1);   add(0, 0, 6, 1);   add(0, 0, 8, 0);
      add(1, 1, 0, 1);   add(1, 1, 2, 59);  add(1, 23, 4, 0);  add(1, 24, 4, 1);
      add(1, 155, 4, 1); add(1, 156, 4, 0); add(1, 16, 5, 1);  add(1, 17, 5, 0);
      add(1, 18, 5, 0);  add(1, 19, 5, 1);  add(1, 160, 6, 1); add(1, 161, 6, 0);
      add(1, 180, 6, 0); add(1, 181, 6, 1); add(1, 20, 9, 1);  add(1, 20, 8, 0);
      add(1, 200, 8, 1); add(1, 200, 9, 1); add(1, 101, 2, 59); add(1, 101, 3, 5);
      add(1, 200, 2, 14); add(1, 200, 3, 9); add(1, 201, 2, 5); add(1, 201, 3, 4);
      add(1, 219, 0, 19); add(1, 220, 1, 1);
      add(3, 0, 0, 0);   add(3, 0, 1, 0);   add(3, 0, 2, 0);   add(3, 0, 5, 1);
      add(3, 0, 7, 0);   add(3, 1, 2, 59);  add(3, 199, 8, 0); add(3, 200, 8, 1);
`ifdef RASTER_IRQ_EN
      add(1, 80, 10, 1); add(1, 20, 10, 0);
`endif

      phase = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

      phase = 1;
      step(1'b0, 1'b0);
      while (k < 2 * FR + 20) begin
         if (k == 100) begin
            bus.scroll_x = 3'd5;
            bus.scroll_y = 3'd2;
         end
         step(1'b0, 1'b1);
      end

      phase = 2;
      bus.raster_line = 5'd20;
      guard = 0;
      while (k < 660 && guard < 2000) begin
         step(1'b0, guard % 4 == 3);
         guard++;
      end
      if (k < 660) begin
         bad++;
         $display("FAIL phase2_budget k=%0d want=660", k);
      end

      phase = 3;
      bus.raster_line = 5'd2;
      step(1'b1, 1'b0);
      guard = 0;
      while (k < FR + 10 && guard < 1200) begin
         step(1'b0, guard % 4 == 3);
         guard++;
      end
      if (k < FR + 10) begin
         bad++;
         $display("FAIL phase3_budget k=%0d want=%0d", k, FR + 10);
      end

      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      for (int j = 0; j < dir.size(); j++) begin
         if (!hit[j]) begin
            bad++;
            $display("FAIL point_unreached ph=%0d k=%0d got=0 want=1", dir[j].ph, dir[j].k);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
